// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - loader_state_t : FSM state encoding of the loader
//   - LANE_W         : width of the byte-lane counter inside a 32-bit word
//   - LEN_W          : width of the big-endian word-count header
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int LANE_W = 2;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        FINISH = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Big-endian 8-to-32 shift register. The first byte of a word ends up in
// bits [31:24].
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   clear      in   session start; empties the register and the lane counter
//   shift_en   in   a byte is transferred this cycle
//   byte_in    in   8-bit stream byte
//   word_next  out  word as it looks once byte_in has been shifted in
//   word_full  out  this transfer completes a word (4th byte)
// ---------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0]       word_q;
    logic [LANE_W-1:0] lane_q;

    // The completed word is presented combinationally so the parent can
    // capture it on the same edge that accepts the 4th byte.
    assign word_next = {word_q[23:0], byte_in};
    assign word_full = shift_en && (lane_q == '1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word_q <= '0;
            lane_q <= '0;
        end else if (shift_en) begin
            word_q <= word_next;
            lane_q <= lane_q + LANE_W'(1);
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// ---------------------------------------------------------------------------
// imem_program_loader
// Writer side of the MIPS instruction-memory load interface. A session is
// started by load_start, reads a 16-bit big-endian word count N, then N
// big-endian 32-bit words, each written to BASE_ADDR + 4*k. PC_reset holds
// the core in reset until a load completes successfully.
//
// Optional feature (macro LOADER_CHECKSUM_EN): after the last word one more
// byte is read and must equal the XOR of all 4N data bytes; a mismatch ends
// the session in ERR.
//
// Ports:
//   clock                    in   system clock
//   reset                    in   synchronous active-high reset
//   load_start               in   one-cycle pulse starting a session
//   byte_in / byte_valid     in   byte stream
//   byte_ready               out  byte accepted when byte_valid && byte_ready
//   inst_memory_load_enable  out  one-cycle write strobe
//   inst_memory_write_addr   out  byte address of the write
//   inst_memory_write_data   out  word written
//   PC_reset                 out  core held in reset (load running / failed)
//   busy                     out  session in progress
//   done                     out  last load succeeded (sticky)
//   error                    out  last load failed (sticky)
// ---------------------------------------------------------------------------
module imem_program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        inst_memory_load_enable,
    output logic [31:0] inst_memory_write_addr,
    output logic [31:0] inst_memory_write_data,
    output logic        PC_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

    loader_state_t state_q, state_next;

    logic             xfer;
    logic             start_ok;
    logic             shift_en;
    logic             word_full;
    logic [31:0]      word_next;
    logic [7:0]       len_hi_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_value;
    logic             len_bad;
    logic [LEN_W-1:0] word_idx_q;
    logic             last_word;
    logic [31:0]      addr_cnt_q;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wr_data_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             pc_reset_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
    logic             csum_match;
`endif

    assign xfer      = byte_valid && byte_ready;
    // A new session may only begin from a quiescent state; load_start is
    // ignored while a session is running.
    assign start_ok  = load_start && ((state_q == IDLE) || (state_q == ERR));
    assign shift_en  = (state_q == DATA) && xfer;
    assign len_value = {len_hi_q, byte_in};
    assign len_bad   = (len_value == '0) || ({1'b0, len_value} > MAX_LEN);
    assign last_word = (word_idx_q == (len_q - LEN_W'(1)));
`ifdef LOADER_CHECKSUM_EN
    assign csum_match = (byte_in == csum_q);
`endif

    word_assembler u_word_assembler (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .shift_en  (shift_en),
        .byte_in   (byte_in),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        byte_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) state_next = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = len_bad ? ERR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                if (word_full) state_next = WRITE;
            end
            WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_next = last_word ? CSUM : DATA;
`else
                state_next = last_word ? FINISH : DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = csum_match ? FINISH : ERR;
            end
`endif
            FINISH: begin
                state_next = IDLE;
            end
            ERR: begin
                if (load_start) state_next = LEN_HI;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_hi_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            addr_cnt_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            pc_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if (start_ok) begin
                busy_q     <= 1'b1;
                pc_reset_q <= 1'b1;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                word_idx_q <= '0;
                addr_cnt_q <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end

            if ((state_q == LEN_HI) && xfer) begin
                len_hi_q <= byte_in;
            end

            if ((state_q == LEN_LO) && xfer) begin
                len_q <= len_value;
                if (len_bad) begin
                    error_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    pc_reset_q <= 1'b1;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            if (shift_en) begin
                csum_q <= csum_q ^ byte_in;
            end
`endif

            // Capture address and word on the 4th-byte edge so both are
            // stable throughout the WRITE cycle and held afterwards.
            if (word_full) begin
                wr_addr_q <= addr_cnt_q;
                wr_data_q <= word_next;
            end

            if ((state_q == WRITE) && !last_word) begin
                word_idx_q <= word_idx_q + LEN_W'(1);
                addr_cnt_q <= addr_cnt_q + 32'd4;
            end

`ifdef LOADER_CHECKSUM_EN
            if ((state_q == CSUM) && xfer && !csum_match) begin
                error_q    <= 1'b1;
                busy_q     <= 1'b0;
                pc_reset_q <= 1'b1;
            end
`endif

            if (state_q == FINISH) begin
                pc_reset_q <= 1'b0;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
            end
        end
    end

    assign inst_memory_load_enable = (state_q == WRITE);
    assign inst_memory_write_addr  = wr_addr_q;
    assign inst_memory_write_data  = wr_data_q;
    assign PC_reset                = pc_reset_q;
    assign busy                    = busy_q;
    assign done                    = done_q;
    assign error                   = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_program_loader
// Bench for imem_program_loader: directed sessions from the test plan plus
// randomized sessions checked against a behavioural model of the load
// protocol. Honours LOADER_CHECKSUM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_imem_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    typedef logic [7:0] byte_q_t[$];

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        inst_memory_load_enable;
    logic [31:0] inst_memory_write_addr;
    logic [31:0] inst_memory_write_data;
    logic        PC_reset;
    logic        busy;
    logic        done;
    logic        error;

    imem_program_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .load_start              (load_start),
        .byte_in                 (byte_in),
        .byte_valid              (byte_valid),
        .byte_ready              (byte_ready),
        .inst_memory_load_enable (inst_memory_load_enable),
        .inst_memory_write_addr  (inst_memory_write_addr),
        .inst_memory_write_data  (inst_memory_write_data),
        .PC_reset                (PC_reset),
        .busy                    (busy),
        .done                    (done),
        .error                   (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          strobe_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next write the model predicted.
    always @(negedge clock) begin
        if (inst_memory_load_enable === 1'b1) begin
            strobe_cnt++;
            check("ready_in_write", 32'(byte_ready), 32'd0);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_strobe", 32'(strobe_cnt), 32'd0);
            end else begin
                check("wr_addr", inst_memory_write_addr, exp_addr_q.pop_front());
                check("wr_data", inst_memory_write_data, exp_data_q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the transfer.
    task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap,
                             input bit poke_start);
        int gap;
        int t;
        gap = $urandom_range(max_gap, min_gap);
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(negedge clock);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        load_start = poke_start;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clock);
        byte_valid = 1'b0;
        load_start = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic run_session(input int n, input byte_q_t data, input bit bad_csum,
                               input int min_gap, input int max_gap);
        logic [15:0] nl;
        logic [7:0]  x;
        bit          len_ok;
        bit          exp_ok;
        int          t;
        nl = 16'(n);
        exp_addr_q.delete();
        exp_data_q.delete();
        strobe_cnt = 0;
        len_ok = (n >= 1) && (n <= MAXW);
        exp_ok = len_ok;
        x = 8'h00;
        if (len_ok) begin
            for (int k = 0; k < n; k++) begin
                exp_addr_q.push_back(BASE + 32'(4 * k));
                exp_data_q.push_back({data[4*k], data[4*k+1], data[4*k+2], data[4*k+3]});
            end
            for (int i = 0; i < 4 * n; i++) x = x ^ data[i];
        end
`ifdef LOADER_CHECKSUM_EN
        if (bad_csum) exp_ok = 1'b0;
`endif

        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        check("busy_start", 32'(busy), 32'd1);
        check("pc_start", 32'(PC_reset), 32'd1);
        check("done_clr", 32'(done), 32'd0);
        check("error_clr", 32'(error), 32'd0);

        send_byte(nl[15:8], min_gap, max_gap, 1'b0);
        send_byte(nl[7:0], min_gap, max_gap, 1'b0);
        if (len_ok) begin
            for (int i = 0; i < 4 * n; i++)
                send_byte(data[i], min_gap, max_gap, ($urandom_range(0, 7) == 0));
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_csum ? (x ^ 8'h01) : x, min_gap, max_gap, 1'b0);
`else
            // In the WRITE cycle now: FINISH follows, PC_reset drops after it.
            @(negedge clock);
            check("pc_in_finish", 32'(PC_reset), 32'd1);
            check("busy_in_finish", 32'(busy), 32'd1);
            @(negedge clock);
            check("pc_after_finish", 32'(PC_reset), 32'd0);
`endif
        end

        t = 0;
        while (busy && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        check("done_end", 32'(done), 32'(exp_ok));
        check("error_end", 32'(error), 32'(!exp_ok));
        check("pc_end", 32'(PC_reset), 32'(!exp_ok));
        check("strobe_count", 32'(strobe_cnt), len_ok ? 32'(n) : 32'd0);
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        byte_q_t d;
        int      n;
        bit      bad;

        reset      = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_pc", 32'(PC_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(inst_memory_load_enable), 32'd0);
        check("rst_addr", inst_memory_write_addr, 32'd0);
        check("rst_data", inst_memory_write_data, 32'd0);

        // Normal two-word load.
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
        run_session(2, d, 1'b0, 0, 0);
        check("hold_addr", inst_memory_write_addr, 32'h4);
        check("hold_data", inst_memory_write_data, 32'h0000_002A);

        // Length errors.
        d = {};
        run_session(0, d, 1'b0, 0, 0);
        run_session(257, d, 1'b0, 0, 0);

        // Stalls: byte_valid toggles every other cycle.
        d = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_session(1, d, 1'b0, 1, 1);

        // Mid-load reset after the 2nd data byte.
        exp_addr_q.delete();
        exp_data_q.delete();
        strobe_cnt = 0;
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        send_byte(8'h00, 0, 0, 1'b0);
        send_byte(8'h02, 0, 0, 1'b0);
        send_byte(8'h11, 0, 0, 1'b0);
        send_byte(8'h22, 0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_rst_strobes", 32'(strobe_cnt), 32'd0);
        check("mid_rst_pc", 32'(PC_reset), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_addr", inst_memory_write_addr, 32'd0);
        d = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        run_session(2, d, 1'b0, 0, 2);

`ifdef LOADER_CHECKSUM_EN
        // Word 12 34 56 78: XOR is 0x08.
        d = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_session(1, d, 1'b0, 0, 0);
        run_session(1, d, 1'b1, 0, 0);
        check("csum_bad_data_kept", inst_memory_write_data, 32'h1234_5678);
`endif

        // Randomized sessions.
        for (int s = 0; s < 24; s++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(257, 65535);
            else             n = $urandom_range(1, 5);
            d = {};
            if (n >= 1 && n <= MAXW)
                for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
            bad = ($urandom_range(0, 2) == 0);
            run_session(n, d, bad, 0, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
